// File: rtl/dma_stream_framer_pkg.sv
// Shared state encodings and length/keep helpers for the DMA stream framer.
// Helpers work at maximum widths; callers size-cast results to their own widths.
package dma_stream_framer_pkg;

    localparam int MAX_CNT_W  = 64;
    localparam int MAX_KEEP_W = 128;

    typedef logic [0:0] state_t;
    localparam state_t S_HDR  = 1'b0;
    localparam state_t S_BODY = 1'b1;

    // Low-order byte enables for a final beat; r == 0 means the beat is full.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int unsigned r, input int unsigned b);
        int unsigned n;
        n = (r == 0) ? b : r;
        return ~({MAX_KEEP_W{1'b1}} << n);
    endfunction

    // Beats needed to carry len; byte lengths round up to whole beats.
    function automatic logic [MAX_CNT_W-1:0] len_to_beats(input logic [MAX_CNT_W-1:0] len,
                                                           input bit in_bytes,
                                                           input int unsigned b);
        logic [MAX_CNT_W-1:0] rem_mask;
        if (!in_bytes || b <= 1)
            return len;
        rem_mask = MAX_CNT_W'(b - 1);
        return (len >> $clog2(b)) + MAX_CNT_W'((len & rem_mask) != '0);
    endfunction

endpackage

// File: rtl/dma_stream_framer_out_reg.sv
// One-entry AXI-Stream register slice carrying data/last/keep; 1-cycle latency, full rate.
// Upstream ready is !out_valid || out_ready, so the held beat stays stable under backpressure.
module axis_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_valid,
    input  logic              out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_keep  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
            out_keep  <= in_keep;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dma_stream_framer.sv
// Parses a length header per packet, optionally strips it, and generates m_last/m_keep for S2MM DMA.
// One registered output stage: 1-cycle latency, 1 beat/cycle, s_ready = !m_valid || m_ready.
module dma_stream_framer
    import dma_stream_framer_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 32,
    parameter int LEN_IN_BYTES = 0,
    parameter int STRIP_HDR    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [DATA_W/8-1:0] m_keep,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]    beat_rem,
    output logic                busy,
    output logic                zero_len_err
);

    localparam int KEEP_W = DATA_W / 8;

    state_t              state;
    logic [KEEP_W-1:0]   last_keep_q;
    logic [CNT_W-1:0]    hdr_len;
    logic [CNT_W-1:0]    hdr_beats;
    int unsigned         hdr_rem;
    logic                accept;
    logic                load;
    logic                ld_last;
    logic [KEEP_W-1:0]   ld_keep;

    assign hdr_len   = s_data[CNT_W-1:0];
    assign hdr_beats = CNT_W'(len_to_beats(MAX_CNT_W'(hdr_len), LEN_IN_BYTES != 0, KEEP_W));
    assign hdr_rem   = 32'(hdr_len) & 32'(KEEP_W - 1);

    assign accept = s_valid && s_ready;
    // A stripped header is consumed without occupying the output register.
    assign load   = accept && ((state == S_BODY) || (STRIP_HDR == 0));
    assign busy   = (state == S_BODY);

    always_comb begin
        ld_last = 1'b0;
        ld_keep = '1;
        if (state == S_HDR) begin
            ld_last = (hdr_beats == '0);
        end else if (beat_rem == CNT_W'(1)) begin
            ld_last = 1'b1;
            ld_keep = last_keep_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_HDR;
            beat_rem     <= '0;
            pkt_cnt      <= '0;
            zero_len_err <= 1'b0;
            last_keep_q  <= '0;
        end else begin
            zero_len_err <= 1'b0;
            if (m_valid && m_ready && m_last)
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            if (accept) begin
                if (state == S_HDR) begin
                    beat_rem    <= hdr_beats;
                    last_keep_q <= (LEN_IN_BYTES != 0) ? KEEP_W'(keep_mask(hdr_rem, KEEP_W)) : '1;
                    if (hdr_beats != '0)
                        state <= S_BODY;
                    else if (STRIP_HDR != 0)
                        zero_len_err <= 1'b1;
                end else begin
                    // beat_rem is at least 1 in S_BODY, so this cannot underflow.
                    beat_rem <= beat_rem - CNT_W'(1);
                    if (beat_rem == CNT_W'(1))
                        state <= S_HDR;
                end
            end
        end
    end

    axis_out_reg #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .in_data   (s_data),
        .in_last   (ld_last),
        .in_keep   (ld_keep),
        .in_valid  (load),
        .in_ready  (s_ready),
        .out_data  (m_data),
        .out_last  (m_last),
        .out_keep  (m_keep),
        .out_valid (m_valid),
        .out_ready (m_ready)
    );

endmodule

// File: tb/tb_dma_stream_framer.sv
// Directed bench: instance a = beat lengths, header forwarded; instance b = byte lengths, header stripped.
module tb_dma_stream_framer;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] a_data, a_mdata, a_pkt, a_rem;
    logic        a_valid, a_sready, a_mvalid, a_mready, a_mlast, a_busy, a_zerr;
    logic [3:0]  a_mkeep;

    logic [31:0] b_data, b_mdata, b_pkt, b_rem;
    logic        b_valid, b_sready, b_mvalid, b_mready, b_mlast, b_busy, b_zerr;
    logic [3:0]  b_mkeep;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_stream_framer #(.DATA_W(32), .CNT_W(32), .LEN_IN_BYTES(0), .STRIP_HDR(0)) u_a (
        .clk(clk), .reset(reset), .s_data(a_data), .s_valid(a_valid), .s_ready(a_sready),
        .m_data(a_mdata), .m_valid(a_mvalid), .m_ready(a_mready), .m_last(a_mlast),
        .m_keep(a_mkeep), .pkt_cnt(a_pkt), .beat_rem(a_rem), .busy(a_busy),
        .zero_len_err(a_zerr));

    dma_stream_framer #(.DATA_W(32), .CNT_W(32), .LEN_IN_BYTES(1), .STRIP_HDR(1)) u_b (
        .clk(clk), .reset(reset), .s_data(b_data), .s_valid(b_valid), .s_ready(b_sready),
        .m_data(b_mdata), .m_valid(b_mvalid), .m_ready(b_mready), .m_last(b_mlast),
        .m_keep(b_mkeep), .pkt_cnt(b_pkt), .beat_rem(b_rem), .busy(b_busy),
        .zero_len_err(b_zerr));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] w1 [4] = '{32'd3, 32'hA0, 32'hA1, 32'hA2};
    logic [31:0] w2 [3] = '{32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2};
    logic [31:0] w5 [5] = '{32'd2, 32'hC0, 32'hC1, 32'd1, 32'hE0};
    logic        l5 [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        reset = 1'b1;
        a_data = '0; a_valid = 1'b0; a_mready = 1'b0;
        b_data = '0; b_valid = 1'b0; b_mready = 1'b0;
        tick; tick;
        chk("rst_mvalid", a_mvalid, 0);
        chk("rst_mlast",  a_mlast,  0);
        chk("rst_mkeep",  a_mkeep,  0);
        chk("rst_mdata",  a_mdata,  0);
        chk("rst_pkt",    a_pkt,    0);
        chk("rst_rem",    a_rem,    0);
        chk("rst_busy",   a_busy,   0);
        chk("rst_zerr",   b_zerr,   0);
        reset = 1'b0;

        // Beat-length packet of 3 with header forwarded.
        a_mready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = w1[i]; a_valid = 1'b1;
            tick;
            chk("t1_mvalid", a_mvalid, 1);
            chk("t1_mdata",  a_mdata,  w1[i]);
            chk("t1_mlast",  a_mlast,  (i == 3));
            chk("t1_mkeep",  a_mkeep,  4'hF);
            chk("t1_rem",    a_rem,    3 - (i == 0 ? 0 : i));
            chk("t1_busy",   a_busy,   (i != 3));
        end
        chk("t1_pkt_before", a_pkt, 0);
        a_valid = 1'b0;
        tick;
        chk("t1_pkt_after", a_pkt, 1);
        chk("t1_idle", a_mvalid, 0);

        // 10-byte packet, header stripped: 3 beats, last keep 0011.
        b_mready = 1'b1;
        b_data = 32'd10; b_valid = 1'b1;
        tick;
        chk("t2_hdr_nofwd", b_mvalid, 0);
        chk("t2_rem_hdr",   b_rem,    3);
        chk("t2_busy",      b_busy,   1);
        for (int i = 0; i < 3; i++) begin
            b_data = w2[i];
            tick;
            chk("t2_mvalid", b_mvalid, 1);
            chk("t2_mdata",  b_mdata,  w2[i]);
            chk("t2_mlast",  b_mlast,  (i == 2));
            chk("t2_mkeep",  b_mkeep,  (i == 2) ? 4'b0011 : 4'hF);
            chk("t2_rem",    b_rem,    2 - i);
        end
        b_valid = 1'b0;
        tick;
        chk("t2_pkt",  b_pkt,  1);
        chk("t2_idle", b_busy, 0);

        // Zero-length header, forwarded then stripped.
        a_data = 32'd0; a_valid = 1'b1;
        tick;
        chk("t3a_mvalid", a_mvalid, 1);
        chk("t3a_mlast",  a_mlast,  1);
        chk("t3a_mkeep",  a_mkeep,  4'hF);
        chk("t3a_busy",   a_busy,   0);
        a_valid = 1'b0;
        tick;
        chk("t3a_pkt", a_pkt, 2);
        b_data = 32'd0; b_valid = 1'b1;
        tick;
        chk("t3b_zerr_hi", b_zerr,   1);
        chk("t3b_nobeat",  b_mvalid, 0);
        chk("t3b_busy",    b_busy,   0);
        b_valid = 1'b0;
        tick;
        chk("t3b_zerr_lo", b_zerr,   0);
        chk("t3b_nobeat2", b_mvalid, 0);

        // Backpressure: 5 stalled cycles mid-packet.
        a_data = 32'd4; a_valid = 1'b1;
        tick;
        a_data = 32'hD0;
        tick;
        chk("t4_rem_b0", a_rem, 3);
        a_mready = 1'b0;
        a_data = 32'hD1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t4_sready", a_sready, 0);
            chk("t4_hold_d", a_mdata,  32'hD0);
            chk("t4_hold_l", a_mlast,  0);
            chk("t4_hold_k", a_mkeep,  4'hF);
            chk("t4_rem",    a_rem,    3);
        end
        a_mready = 1'b1;
        tick;
        chk("t4_d1", a_mdata, 32'hD1);
        a_data = 32'hD2;
        tick;
        chk("t4_d2", a_mdata, 32'hD2);
        chk("t4_d2_last", a_mlast, 0);
        a_data = 32'hD3;
        tick;
        chk("t4_d3", a_mdata, 32'hD3);
        chk("t4_d3_last", a_mlast, 1);
        a_valid = 1'b0;
        tick;
        chk("t4_pkt", a_pkt, 3);

        // Back-to-back packets after a fresh reset.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_data = w5[i]; a_valid = 1'b1;
            tick;
            chk("t5_sready", a_sready, 1);
            chk("t5_mdata",  a_mdata,  w5[i]);
            chk("t5_mlast",  a_mlast,  l5[i]);
        end
        a_valid = 1'b0;
        tick;
        chk("t5_pkt", a_pkt, 2);

        // Reset while in the body with 5 beats remaining.
        a_data = 32'd7; a_valid = 1'b1;
        tick;
        a_data = 32'hF0;
        tick;
        a_data = 32'hF1;
        tick;
        chk("t6_rem5", a_rem,  5);
        chk("t6_busy", a_busy, 1);
        reset = 1'b1;
        tick;
        chk("t6_mvalid", a_mvalid, 0);
        chk("t6_mlast",  a_mlast,  0);
        chk("t6_mkeep",  a_mkeep,  0);
        chk("t6_mdata",  a_mdata,  0);
        chk("t6_pkt",    a_pkt,    0);
        chk("t6_rem",    a_rem,    0);
        chk("t6_busy0",  a_busy,   0);
        reset = 1'b0;
        a_data = 32'd1;
        tick;
        chk("t6_hdr_rem",  a_rem,   1);
        chk("t6_hdr_busy", a_busy,  1);
        chk("t6_hdr_last", a_mlast, 0);
        a_data = 32'h99;
        tick;
        chk("t6_body_last", a_mlast, 1);
        chk("t6_body_data", a_mdata, 32'h99);
        a_valid = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dma_stream_framer.md
Name: dma_stream_framer

Overview:
- Parametrised successor to the single-width DMA last/keep generator.
- Sits between a kernel output stream and the AXI-Stream S2MM DMA input.
- Parses a length header at the start of each packet, optionally strips it, and drives m_last and m_keep, including a partial m_keep on the final beat in byte-length mode.
- Adds a registered output stage, a packet counter and zero-length detection.

Parameters:
- DATA_W, 32: stream data width in bits; a power-of-two multiple of 8, at least 8.
- CNT_W, 32: length/counter width; header length = s_data[CNT_W-1:0]; CNT_W <= DATA_W.
- LEN_IN_BYTES, 0: 0 = header gives payload beats; 1 = header gives payload bytes.
- STRIP_HDR, 0: 0 = header word forwarded as the first beat; 1 = header consumed, not forwarded.

Ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- s_data  in  DATA_W  upstream data.
- s_valid  in  1  upstream valid.
- s_ready  out  1  upstream ready.
- m_data  out  DATA_W  data to DMA.
- m_valid  out  1  valid to DMA.
- m_ready  in  1  DMA ready.
- m_last  out  1  final beat of packet.
- m_keep  out  DATA_W/8  byte enables.
- pkt_cnt  out  CNT_W  packets completed at the output since reset; wraps.
- beat_rem  out  CNT_W  payload beats still to accept in the current packet.
- busy  out  1  high in S_BODY.
- zero_len_err  out  1  one-cycle pulse on a zero-length header when STRIP_HDR=1.

Behaviour:
- Reset, synchronous, active-high:
  - state = S_HDR.
  - m_valid, m_last, m_keep, m_data, pkt_cnt, beat_rem, busy and zero_len_err all 0.
  - Reset mid-packet drops the output register contents and any partial packet.
- Output register (1 entry):
  - s_ready = !m_valid || m_ready.
  - Input accept = s_valid && s_ready.
  - Latency from accept to m_valid is 1 cycle; full throughput of 1 beat/cycle.
  - m_data, m_last and m_keep stay stable while m_valid && !m_ready.
- Beat count N:
  - LEN_IN_BYTES=0: N = len.
  - LEN_IN_BYTES=1, B = DATA_W/8: N = (len >> log2 B) + (len[log2B-1:0] != 0), computed without overflow.
- S_HDR, on accept:
  - Latch len and N; beat_rem <= N.
  - STRIP_HDR=0: load the header into the output register with m_keep all-ones. m_last = (N==0). If N==0 stay in S_HDR, else go to S_BODY.
  - STRIP_HDR=1: nothing is loaded into the output register. If N==0, pulse zero_len_err and stay in S_HDR; else go to S_BODY.
- S_BODY, on accept:
  - Load the beat and decrement beat_rem.
  - If beat_rem==1: m_last=1 and go to S_HDR. m_keep = all-ones, except when LEN_IN_BYTES=1 and r = len mod B != 0, in which case m_keep = (1<<r)-1 (low bytes valid).
  - Otherwise m_last=0 and m_keep all-ones.
- pkt_cnt increments on m_valid && m_ready && m_last.
- A header accept immediately following a last-beat accept is legal (back-to-back packets with no idle cycle).
- Maximum length 2^CNT_W-1 is supported; beat_rem never underflows.

Decomposition:
- Package dma_stream_framer_pkg:
  - state enum {S_HDR, S_BODY}.
  - function keep_mask(r, B).
  - function len_to_beats(len, LEN_IN_BYTES, B).
- One sub-module: axis_out_reg (1-entry AXI-Stream register slice carrying data/last/keep). It is reusable by other DMA-side blocks.

Test Plan:
- DATA_W=32, STRIP_HDR=0, LEN_IN_BYTES=0; header 3 then D0..D2 with m_ready=1 → 4 output beats; m_last only on D2; m_keep=4'hF on all beats; pkt_cnt 0→1.
- LEN_IN_BYTES=1, STRIP_HDR=1; header 10 then 3 words → header not output; 3 beats; last beat m_keep=4'b0011 with m_last=1; beat_rem goes 3,2,1,0.
- STRIP_HDR=0; header 0 → single beat with m_last=1 and m_keep=4'hF; busy stays 0. Repeat with STRIP_HDR=1 → no output beat; zero_len_err high for exactly 1 cycle.
- Hold m_ready=0 for 5 cycles mid-packet → s_ready=0 after the register fills; m_data/m_last/m_keep held stable; no beat lost or duplicated after release.
- Back-to-back packets (len 2, len 1) with continuous s_valid → correct m_last positions; pkt_cnt=2; no idle cycle needed between packets.
- Assert reset during S_BODY with beat_rem=5 → next cycle all outputs 0 and state S_HDR; the next word is treated as a header.
